// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
//
// Registered RV32I / RV32IM instruction decode stage between fetch and
// execute. It takes one instruction per accept cycle, decodes it into a
// control bundle plus a sign-extended immediate, and holds that bundle until
// execute consumes it. Once execute consumes a load or store, a small FSM
// stops new instructions from being accepted until the LSU reports
// completion or a wait timeout expires.
//
// Parameters:
//   XLEN        - datapath width (32 or 64); sets the width of pc and imm
//   ENABLE_M    - 1 decodes OP with funct7=0000001 as M-extension ops
//   MEM_TIMEOUT - number of MEM_WAIT cycles before abort; 0 disables it
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   instr_i, pc_i          fetched instruction and its PC
//   instr_valid_i/_ready_o fetch-side handshake
//   flush_i                drops the held bundle and any memory wait
//   mem_done_i             LSU finished the outstanding access
//   dec_valid_o/ready_i    execute-side handshake
//   pc_o .. imm_o          decoded bundle fields
//   reg_write_o .. lui_o   control flags
//   illegal_o              bundle carries an illegal encoding
//   mem_busy_o             FSM is waiting on memory
//   mem_timeout_o          one-cycle pulse when a memory wait is aborted
// ---------------------------------------------------------------------------
module decode_stage #(
    parameter int XLEN        = 32,
    parameter int ENABLE_M    = 0,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            instr_valid_i,
    output logic            instr_ready_o,
    input  logic            flush_i,
    input  logic            mem_done_i,
    output logic            dec_valid_o,
    input  logic            dec_ready_i,
    output logic [XLEN-1:0] pc_o,
    output logic [4:0]      alu_op_o,
    output logic [4:0]      rs1_o,
    output logic [4:0]      rs2_o,
    output logic [4:0]      rd_o,
    output logic [2:0]      funct3_o,
    output logic [XLEN-1:0] imm_o,
    output logic            reg_write_o,
    output logic            branch_o,
    output logic            jump_o,
    output logic            jalr_o,
    output logic            mem_read_o,
    output logic            mem_write_o,
    output logic            mem_to_reg_o,
    output logic            use_imm_o,
    output logic            use_pc_o,
    output logic            lui_o,
    output logic            illegal_o,
    output logic            mem_busy_o,
    output logic            mem_timeout_o
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SLT  = 5'b00001;
    localparam logic [4:0] ALU_AND  = 5'b00010;
    localparam logic [4:0] ALU_OR   = 5'b00011;
    localparam logic [4:0] ALU_XOR  = 5'b00100;
    localparam logic [4:0] ALU_SLL  = 5'b00101;
    localparam logic [4:0] ALU_SRL  = 5'b00110;
    localparam logic [4:0] ALU_SUB  = 5'b00111;
    localparam logic [4:0] ALU_SRA  = 5'b01000;
    localparam logic [4:0] ALU_SLTU = 5'b01001;

    // Counter just wide enough to hold MEM_TIMEOUT.
    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CW:0] TIMEOUT_VAL = (CW + 1)'(MEM_TIMEOUT);

    typedef enum logic {
        ST_RUN,
        ST_MEM_WAIT
    } state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW:0]   cnt_inc;
    logic        timeout_d;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        shift_hi_zero;
    logic        shift_hi_sra;
    logic [31:0] imm_i32, imm_s32, imm_b32, imm_u32, imm_j32;

    logic [4:0]  d_alu_op;
    logic [31:0] d_imm32;
    logic        d_reg_write, d_branch, d_jump, d_jalr;
    logic        d_mem_read, d_mem_write, d_mem_to_reg;
    logic        d_use_imm, d_use_pc, d_lui, d_illegal;

    logic        accept;
    logic        consume;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];

    // On RV64 the shift amount grows to six bits, so only instr[31:26]
    // distinguishes logical from arithmetic shifts.
    assign shift_hi_zero = (XLEN == 64) ? (instr_i[31:26] == 6'b000000)
                                        : (funct7 == 7'b0000000);
    assign shift_hi_sra  = (XLEN == 64) ? (instr_i[31:26] == 6'b010000)
                                        : (funct7 == 7'b0100000);

    assign imm_i32 = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b32 = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_u32 = {instr_i[31:12], 12'b0};
    assign imm_j32 = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

    assign instr_ready_o = (state_q == ST_RUN) && (!dec_valid_o || dec_ready_i) && !flush_i;
    assign accept        = instr_valid_i && instr_ready_o;
    assign consume       = dec_valid_o && dec_ready_i;
    assign mem_busy_o    = (state_q == ST_MEM_WAIT);

    // Combinational decode of the incoming instruction. Every class sets its
    // own flags on top of an all-zero default; anything illegal is squashed
    // back to a harmless bundle at the end so execute never acts on it.
    always_comb begin
        d_alu_op     = ALU_ADD;
        d_imm32      = imm_i32;
        d_reg_write  = 1'b0;
        d_branch     = 1'b0;
        d_jump       = 1'b0;
        d_jalr       = 1'b0;
        d_mem_read   = 1'b0;
        d_mem_write  = 1'b0;
        d_mem_to_reg = 1'b0;
        d_use_imm    = 1'b0;
        d_use_pc     = 1'b0;
        d_lui        = 1'b0;
        d_illegal    = 1'b0;

        case (opcode)
            OPC_LUI: begin
                d_imm32     = imm_u32;
                d_reg_write = 1'b1;
                d_use_imm   = 1'b1;
                d_lui       = 1'b1;
            end
            OPC_AUIPC: begin
                d_imm32     = imm_u32;
                d_reg_write = 1'b1;
                d_use_imm   = 1'b1;
                d_use_pc    = 1'b1;
            end
            OPC_JAL: begin
                d_imm32     = imm_j32;
                d_reg_write = 1'b1;
                d_jump      = 1'b1;
                d_use_imm   = 1'b1;
                d_use_pc    = 1'b1;
            end
            OPC_JALR: begin
                d_reg_write = 1'b1;
                d_jump      = 1'b1;
                d_jalr      = 1'b1;
                d_use_imm   = 1'b1;
                d_illegal   = (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                d_imm32  = imm_b32;
                d_branch = 1'b1;
                case (funct3[2:1])
                    2'b00:   d_alu_op = ALU_SUB;
                    2'b10:   d_alu_op = ALU_SLT;
                    2'b11:   d_alu_op = ALU_SLTU;
                    default: d_illegal = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                d_reg_write  = 1'b1;
                d_mem_read   = 1'b1;
                d_mem_to_reg = 1'b1;
                d_use_imm    = 1'b1;
                d_illegal    = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            OPC_STORE: begin
                d_imm32     = imm_s32;
                d_mem_write = 1'b1;
                d_use_imm   = 1'b1;
                d_illegal   = (funct3 > 3'b010);
            end
            OPC_OPIMM: begin
                d_reg_write = 1'b1;
                d_use_imm   = 1'b1;
                case (funct3)
                    3'b000: d_alu_op = ALU_ADD;
                    3'b010: d_alu_op = ALU_SLT;
                    3'b011: d_alu_op = ALU_SLTU;
                    3'b100: d_alu_op = ALU_XOR;
                    3'b110: d_alu_op = ALU_OR;
                    3'b111: d_alu_op = ALU_AND;
                    3'b001: begin
                        d_alu_op  = ALU_SLL;
                        d_illegal = !shift_hi_zero;
                    end
                    default: begin
                        d_alu_op  = shift_hi_sra ? ALU_SRA : ALU_SRL;
                        d_illegal = !(shift_hi_zero || shift_hi_sra);
                    end
                endcase
            end
            OPC_OP: begin
                d_reg_write = 1'b1;
                if (funct7 == 7'b0000000) begin
                    case (funct3)
                        3'b000:  d_alu_op = ALU_ADD;
                        3'b001:  d_alu_op = ALU_SLL;
                        3'b010:  d_alu_op = ALU_SLT;
                        3'b011:  d_alu_op = ALU_SLTU;
                        3'b100:  d_alu_op = ALU_XOR;
                        3'b101:  d_alu_op = ALU_SRL;
                        3'b110:  d_alu_op = ALU_OR;
                        default: d_alu_op = ALU_AND;
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    d_alu_op = ALU_SUB;
                end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
                    d_alu_op = ALU_SRA;
                end else if (funct7 == 7'b0000001 && ENABLE_M != 0) begin
                    d_alu_op = {2'b10, funct3};
                end else begin
                    d_illegal = 1'b1;
                end
            end
            OPC_FENCE: begin
                // Nothing to do downstream: a legal bundle with no effects.
            end
            default: d_illegal = 1'b1;
        endcase

        if (instr_i[1:0] != 2'b11) begin
            d_illegal = 1'b1;
        end

        if (d_illegal) begin
            d_alu_op     = ALU_ADD;
            d_reg_write  = 1'b0;
            d_branch     = 1'b0;
            d_jump       = 1'b0;
            d_jalr       = 1'b0;
            d_mem_read   = 1'b0;
            d_mem_write  = 1'b0;
            d_mem_to_reg = 1'b0;
            d_use_imm    = 1'b0;
            d_use_pc     = 1'b0;
            d_lui        = 1'b0;
        end
    end

    // Output bundle register. Flush wins over everything, then a new
    // accept reloads the bundle (even if the old one is consumed in the
    // same cycle), otherwise a consumed bundle simply goes invalid while
    // the fields keep their last values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dec_valid_o  <= 1'b0;
            pc_o         <= '0;
            alu_op_o     <= '0;
            rs1_o        <= '0;
            rs2_o        <= '0;
            rd_o         <= '0;
            funct3_o     <= '0;
            imm_o        <= '0;
            reg_write_o  <= 1'b0;
            branch_o     <= 1'b0;
            jump_o       <= 1'b0;
            jalr_o       <= 1'b0;
            mem_read_o   <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_to_reg_o <= 1'b0;
            use_imm_o    <= 1'b0;
            use_pc_o     <= 1'b0;
            lui_o        <= 1'b0;
            illegal_o    <= 1'b0;
        end else if (flush_i) begin
            dec_valid_o <= 1'b0;
        end else if (accept) begin
            dec_valid_o  <= 1'b1;
            pc_o         <= pc_i;
            alu_op_o     <= d_alu_op;
            rs1_o        <= instr_i[19:15];
            rs2_o        <= instr_i[24:20];
            rd_o         <= instr_i[11:7];
            funct3_o     <= funct3;
            imm_o        <= XLEN'($signed(d_imm32));
            reg_write_o  <= d_reg_write;
            branch_o     <= d_branch;
            jump_o       <= d_jump;
            jalr_o       <= d_jalr;
            mem_read_o   <= d_mem_read;
            mem_write_o  <= d_mem_write;
            mem_to_reg_o <= d_mem_to_reg;
            use_imm_o    <= d_use_imm;
            use_pc_o     <= d_use_pc;
            lui_o        <= d_lui;
            illegal_o    <= d_illegal;
        end else if (consume) begin
            dec_valid_o <= 1'b0;
        end
    end

    // Memory-wait FSM state, wait counter and the registered timeout pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_RUN;
            cnt_q         <= '0;
            mem_timeout_o <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            mem_timeout_o <= timeout_d;
        end
    end

    // Next-state logic. The timeout fires in the wait cycle where the
    // counter would reach MEM_TIMEOUT; a completion in that same cycle takes
    // precedence so a finished access is never reported as aborted.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        cnt_inc   = (CW + 1)'(cnt_q) + (CW + 1)'(1);

        if (flush_i) begin
            state_d = ST_RUN;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    cnt_d = '0;
                    if (consume && (mem_read_o || mem_write_o)) begin
                        state_d = ST_MEM_WAIT;
                    end
                end
                default: begin
                    if (mem_done_i) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else if (MEM_TIMEOUT != 0 && cnt_inc == TIMEOUT_VAL) begin
                        state_d   = ST_RUN;
                        cnt_d     = '0;
                        timeout_d = 1'b1;
                    end else if (cnt_q != '1) begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_stage
//
// Directed bench for decode_stage. Two instances share all inputs:
//   dut_a : ENABLE_M=0, MEM_TIMEOUT=255
//   dut_b : ENABLE_M=1, MEM_TIMEOUT=4
// Inputs change 1 time unit after the rising edge and outputs are sampled
// 1 time unit later, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_decode_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        instr_valid;
    logic        flush;
    logic        mem_done;
    logic        dec_ready;

    logic        a_instr_ready, a_dec_valid;
    logic [31:0] a_pc, a_imm;
    logic [4:0]  a_alu_op, a_rs1, a_rs2, a_rd;
    logic [2:0]  a_funct3;
    logic        a_reg_write, a_branch, a_jump, a_jalr, a_mem_read, a_mem_write;
    logic        a_mem_to_reg, a_use_imm, a_use_pc, a_lui, a_illegal;
    logic        a_mem_busy, a_mem_timeout;

    logic        b_instr_ready, b_dec_valid;
    logic [31:0] b_pc, b_imm;
    logic [4:0]  b_alu_op, b_rs1, b_rs2, b_rd;
    logic [2:0]  b_funct3;
    logic        b_reg_write, b_branch, b_jump, b_jalr, b_mem_read, b_mem_write;
    logic        b_mem_to_reg, b_use_imm, b_use_pc, b_lui, b_illegal;
    logic        b_mem_busy, b_mem_timeout;

    int check_count = 0;
    int error_count = 0;

    decode_stage #(.XLEN(32), .ENABLE_M(0), .MEM_TIMEOUT(255)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .instr_i(instr), .pc_i(pc),
        .instr_valid_i(instr_valid), .instr_ready_o(a_instr_ready),
        .flush_i(flush), .mem_done_i(mem_done),
        .dec_valid_o(a_dec_valid), .dec_ready_i(dec_ready),
        .pc_o(a_pc), .alu_op_o(a_alu_op), .rs1_o(a_rs1), .rs2_o(a_rs2), .rd_o(a_rd),
        .funct3_o(a_funct3), .imm_o(a_imm),
        .reg_write_o(a_reg_write), .branch_o(a_branch), .jump_o(a_jump), .jalr_o(a_jalr),
        .mem_read_o(a_mem_read), .mem_write_o(a_mem_write), .mem_to_reg_o(a_mem_to_reg),
        .use_imm_o(a_use_imm), .use_pc_o(a_use_pc), .lui_o(a_lui), .illegal_o(a_illegal),
        .mem_busy_o(a_mem_busy), .mem_timeout_o(a_mem_timeout)
    );

    decode_stage #(.XLEN(32), .ENABLE_M(1), .MEM_TIMEOUT(4)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .instr_i(instr), .pc_i(pc),
        .instr_valid_i(instr_valid), .instr_ready_o(b_instr_ready),
        .flush_i(flush), .mem_done_i(mem_done),
        .dec_valid_o(b_dec_valid), .dec_ready_i(dec_ready),
        .pc_o(b_pc), .alu_op_o(b_alu_op), .rs1_o(b_rs1), .rs2_o(b_rs2), .rd_o(b_rd),
        .funct3_o(b_funct3), .imm_o(b_imm),
        .reg_write_o(b_reg_write), .branch_o(b_branch), .jump_o(b_jump), .jalr_o(b_jalr),
        .mem_read_o(b_mem_read), .mem_write_o(b_mem_write), .mem_to_reg_o(b_mem_to_reg),
        .use_imm_o(b_use_imm), .use_pc_o(b_use_pc), .lui_o(b_lui), .illegal_o(b_illegal),
        .mem_busy_o(b_mem_busy), .mem_timeout_o(b_mem_timeout)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed flags, MSB first:
    // reg_write branch jump jalr mem_read mem_write mem_to_reg use_imm use_pc lui illegal
    function automatic logic [10:0] flags_a();
        return {a_reg_write, a_branch, a_jump, a_jalr, a_mem_read, a_mem_write,
                a_mem_to_reg, a_use_imm, a_use_pc, a_lui, a_illegal};
    endfunction

    function automatic logic [10:0] flags_b();
        return {b_reg_write, b_branch, b_jump, b_jalr, b_mem_read, b_mem_write,
                b_mem_to_reg, b_use_imm, b_use_pc, b_lui, b_illegal};
    endfunction

    // Single comparison point: counts the check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Move to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one instruction for a single cycle, then settle so the decoded
    // bundle can be sampled.
    task automatic applyStimulus(input logic [31:0] ins, input logic [31:0] pcv);
        instr       = ins;
        pc          = pcv;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        #1;
    endtask

    task automatic resetDut();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    typedef struct packed {
        logic [31:0] ins;
        logic [10:0] flags;
        logic [4:0]  alu;
        logic        alu_chk;
        logic [31:0] imm;
        logic        imm_chk;
    } vec_t;

    vec_t vecs[$];

    localparam logic [31:0] I_ADDI = 32'hFFF00093;
    localparam logic [31:0] I_LW   = 32'h0080A103;
    localparam logic [31:0] I_SW   = 32'h0020A223;
    localparam logic [31:0] I_MUL  = 32'h022081B3;
    localparam logic [31:0] I_BEQ  = 32'hFE208CE3;
    localparam logic [31:0] I_JAL  = 32'hFFDFF0EF;

    initial begin
        rst_n       = 1'b0;
        instr       = 32'h00000013;
        pc          = '0;
        instr_valid = 1'b0;
        flush       = 1'b0;
        mem_done    = 1'b0;
        dec_ready   = 1'b1;

        // Reset state
        #3;
        checkOutput("rst_dec_valid", 32'(a_dec_valid), 32'd0);
        checkOutput("rst_imm",       a_imm, 32'd0);
        checkOutput("rst_flags",     32'(flags_a()), 32'd0);
        checkOutput("rst_busy",      32'(a_mem_busy), 32'd0);
        checkOutput("rst_timeout",   32'(b_mem_timeout), 32'd0);
        tick();
        rst_n = 1'b1;
        #1;

        // ADDI x1,x0,-1
        applyStimulus(I_ADDI, 32'h0000_1000);
        checkOutput("addi_valid", 32'(a_dec_valid), 32'd1);
        checkOutput("addi_alu",   32'(a_alu_op), 32'd0);
        checkOutput("addi_imm",   a_imm, 32'hFFFF_FFFF);
        checkOutput("addi_rd",    32'(a_rd), 32'd1);
        checkOutput("addi_flags", 32'(flags_a()), 32'(11'b10000001000));
        checkOutput("addi_pc",    a_pc, 32'h0000_1000);
        tick();
        checkOutput("addi_drop",  32'(a_dec_valid), 32'd0);

        // Decode table, consumed as it is produced
        vecs.push_back('{32'h402081B3, 11'b10000000000, 5'b00111, 1'b1, 32'h0,         1'b0});
        vecs.push_back('{32'h4030D093, 11'b10000001000, 5'b01000, 1'b1, 32'h0000_0403, 1'b1});
        vecs.push_back('{32'h123452B7, 11'b10000001010, 5'b00000, 1'b1, 32'h1234_5000, 1'b1});
        vecs.push_back('{32'h80000297, 11'b10000001100, 5'b00000, 1'b1, 32'h8000_0000, 1'b1});
        vecs.push_back('{32'h0FF0000F, 11'b00000000000, 5'b00000, 1'b0, 32'h0,         1'b0});
        vecs.push_back('{32'h00C08067, 11'b10110001000, 5'b00000, 1'b1, 32'h0000_000C, 1'b1});
        vecs.push_back('{32'h0020B1B3, 11'b10000000000, 5'b01001, 1'b1, 32'h0,         1'b0});
        vecs.push_back('{32'h0020E863, 11'b01000000000, 5'b01001, 1'b1, 32'h0000_0010, 1'b1});
        vecs.push_back('{32'h00000073, 11'b00000000001, 5'b00000, 1'b0, 32'h0,         1'b0});
        vecs.push_back('{32'h00000001, 11'b00000000001, 5'b00000, 1'b0, 32'h0,         1'b0});
        vecs.push_back('{32'h00002063, 11'b00000000001, 5'b00000, 1'b0, 32'h0,         1'b0});
        vecs.push_back('{32'h00001067, 11'b00000000001, 5'b00000, 1'b0, 32'h0,         1'b0});
        vecs.push_back('{32'h00003003, 11'b00000000001, 5'b00000, 1'b0, 32'h0,         1'b0});
        vecs.push_back('{32'h00003023, 11'b00000000001, 5'b00000, 1'b0, 32'h0,         1'b0});
        vecs.push_back('{32'h4020E1B3, 11'b00000000001, 5'b00000, 1'b0, 32'h0,         1'b0});
        vecs.push_back('{32'h40309093, 11'b00000000001, 5'b00000, 1'b0, 32'h0,         1'b0});
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].ins, 32'h0000_2000 + 32'(i * 4));
            checkOutput($sformatf("vec%0d_valid", i), 32'(a_dec_valid), 32'd1);
            checkOutput($sformatf("vec%0d_flags", i), 32'(flags_a()), 32'(vecs[i].flags));
            if (vecs[i].alu_chk)
                checkOutput($sformatf("vec%0d_alu", i), 32'(a_alu_op), 32'(vecs[i].alu));
            if (vecs[i].imm_chk)
                checkOutput($sformatf("vec%0d_imm", i), a_imm, vecs[i].imm);
        end
        tick();

        // LW with completion after 5 wait cycles
        applyStimulus(I_LW, 32'h0000_3000);
        checkOutput("lw_flags",  32'(flags_a()), 32'(11'b10001011000));
        checkOutput("lw_imm",    a_imm, 32'h0000_0008);
        checkOutput("lw_funct3", 32'(a_funct3), 32'd2);
        checkOutput("lw_ready",  32'(a_instr_ready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 4) mem_done = 1'b1;
            checkOutput($sformatf("lw_busy%0d", i),  32'(a_mem_busy), 32'd1);
            checkOutput($sformatf("lw_ready%0d", i), 32'(a_instr_ready), 32'd0);
        end
        tick();
        mem_done = 1'b0;
        checkOutput("lw_done_busy",  32'(a_mem_busy), 32'd0);
        checkOutput("lw_done_ready", 32'(a_instr_ready), 32'd1);
        checkOutput("lw_no_timeout", 32'(a_mem_timeout), 32'd0);
        resetDut();

        // SW with no completion: dut_b times out after 4 wait cycles
        applyStimulus(I_SW, 32'h0000_4000);
        checkOutput("sw_flags", 32'(flags_b()), 32'(11'b00000101000));
        checkOutput("sw_imm",   b_imm, 32'h0000_0004);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput($sformatf("sw_busy%0d", i),   32'(b_mem_busy), 32'd1);
            checkOutput($sformatf("sw_nopulse%0d", i), 32'(b_mem_timeout), 32'd0);
        end
        tick();
        checkOutput("to_pulse",   32'(b_mem_timeout), 32'd1);
        checkOutput("to_busy",    32'(b_mem_busy), 32'd0);
        checkOutput("to_ready",   32'(b_instr_ready), 32'd1);
        checkOutput("a_still_busy", 32'(a_mem_busy), 32'd1);
        mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
        checkOutput("to_pulse_end", 32'(b_mem_timeout), 32'd0);
        checkOutput("a_released",   32'(a_mem_busy), 32'd0);

        // Completion on the timeout cycle beats the timeout
        applyStimulus(I_SW, 32'h0000_4004);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 3) mem_done = 1'b1;
        end
        tick();
        mem_done = 1'b0;
        checkOutput("race_busy",    32'(b_mem_busy), 32'd0);
        checkOutput("race_nopulse", 32'(b_mem_timeout), 32'd0);

        // MUL with and without the M extension
        applyStimulus(I_MUL, 32'h0000_5000);
        checkOutput("mul_a_illegal", 32'(a_illegal), 32'd1);
        checkOutput("mul_a_rw",      32'(a_reg_write), 32'd0);
        checkOutput("mul_b_illegal", 32'(b_illegal), 32'd0);
        checkOutput("mul_b_alu",     32'(b_alu_op), 32'b10000);
        checkOutput("mul_b_rw",      32'(b_reg_write), 32'd1);
        checkOutput("mul_b_regs",    32'({b_rd, b_rs1, b_rs2}), 32'({5'd3, 5'd1, 5'd2}));
        tick();

        // BEQ held under backpressure, JAL queued behind it
        instr       = I_BEQ;
        pc          = 32'h0000_6000;
        instr_valid = 1'b1;
        dec_ready   = 1'b0;
        tick();
        instr = I_JAL;
        pc    = 32'h0000_6004;
        #1;
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("beq_valid%0d", i), 32'(a_dec_valid), 32'd1);
            checkOutput($sformatf("beq_imm%0d", i),   a_imm, 32'hFFFF_FFF8);
            checkOutput($sformatf("beq_alu%0d", i),   32'(a_alu_op), 32'b00111);
            checkOutput($sformatf("beq_br%0d", i),    32'(flags_a()), 32'(11'b01000000000));
            checkOutput($sformatf("beq_ready%0d", i), 32'(a_instr_ready), 32'd0);
            tick();
        end
        dec_ready = 1'b1;
        #1;
        checkOutput("release_ready", 32'(a_instr_ready), 32'd1);
        tick();
        instr_valid = 1'b0;
        #1;
        checkOutput("jal_valid", 32'(a_dec_valid), 32'd1);
        checkOutput("jal_imm",   a_imm, 32'hFFFF_FFFC);
        checkOutput("jal_flags", 32'(flags_a()), 32'(11'b10100001100));
        checkOutput("jal_pc",    a_pc, 32'h0000_6004);
        tick();
        checkOutput("jal_drop",  32'(a_dec_valid), 32'd0);

        // Flush during MEM_WAIT with a bundle held
        applyStimulus(I_LW, 32'h0000_7000);
        instr       = I_ADDI;
        pc          = 32'h0000_7004;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        dec_ready   = 1'b0;
        #1;
        checkOutput("fl_pre_busy",  32'(a_mem_busy), 32'd1);
        checkOutput("fl_pre_valid", 32'(a_dec_valid), 32'd1);
        checkOutput("fl_pre_ready", 32'(a_instr_ready), 32'd0);
        flush       = 1'b1;
        instr_valid = 1'b1;
        #1;
        checkOutput("fl_ready", 32'(a_instr_ready), 32'd0);
        tick();
        flush       = 1'b0;
        instr_valid = 1'b0;
        #1;
        checkOutput("fl_valid", 32'(a_dec_valid), 32'd0);
        checkOutput("fl_busy",  32'(a_mem_busy), 32'd0);
        checkOutput("fl_ready_after", 32'(a_instr_ready), 32'd1);
        checkOutput("fl_pc_kept", a_pc, 32'h0000_7004);

        // Asynchronous reset while waiting on memory
        dec_ready = 1'b1;
        applyStimulus(I_LW, 32'h0000_8000);
        tick();
        checkOutput("ar_busy_pre", 32'(a_mem_busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("ar_busy",    32'(a_mem_busy), 32'd0);
        checkOutput("ar_memread", 32'(a_mem_read), 32'd0);
        checkOutput("ar_imm",     a_imm, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, parametrised RV32I/RV32IM instruction decode stage between fetch and execute.
- Decodes all base opcodes (LUI, AUIPC, JAL, JALR, branches, loads, stores, OP-IMM, OP, FENCE) and, optionally, the M extension.
- Produces XLEN-wide sign-extended immediates and flags illegal encodings.
- Uses valid/ready on both sides, plus a memory-wait FSM with timeout that stalls issue while a load/store is outstanding.

Parameters:
- XLEN, 32: datapath width (32 or 64); sizes pc and imm.
- ENABLE_M, 0: 1 decodes funct7=0000001 OP instructions as M ops; 0 flags them illegal.
- MEM_TIMEOUT, 255: MEM_WAIT cycles before abort; 0 disables the timeout.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- instr_i  in  32  fetched instruction.
- pc_i  in  XLEN  PC of instr_i.
- instr_valid_i  in  1  fetch offers an instruction.
- instr_ready_o  out  1  stage accepts an instruction this cycle.
- flush_i  in  1  kill the held instruction and any wait.
- mem_done_i  in  1  LSU completed the outstanding access.
- dec_valid_o  out  1  decoded bundle valid.
- dec_ready_i  in  1  execute consumes the bundle.
- pc_o  out  XLEN  registered PC.
- alu_op_o  out  5  ALU op; bit4 set only for M ops.
- rs1_o, rs2_o, rd_o  out  5 each  register indices.
- funct3_o  out  3  raw funct3.
- imm_o  out  XLEN  sign-extended immediate.
- reg_write_o, branch_o, jump_o, jalr_o, mem_read_o, mem_write_o, mem_to_reg_o, use_imm_o, use_pc_o, lui_o  out  1 each  control flags.
- illegal_o  out  1  illegal encoding.
- mem_busy_o  out  1  FSM in MEM_WAIT.
- mem_timeout_o  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset: all outputs 0, FSM = RUN, timeout counter = 0.
- Output register loads on the accept cycle (instr_valid_i && instr_ready_o). Latency is 1 cycle.
- instr_ready_o = (state==RUN) && (!dec_valid_o || dec_ready_i) && !flush_i.
  - Accept and consume may occur in the same cycle; the register reloads.
- When dec_valid_o is high and dec_ready_i is low, the bundle is held stable.
- If dec_valid_o && dec_ready_i && no new accept, dec_valid_o drops next cycle.
- ALU op encodings:
  - ADD 00000, SLT 00001, AND 00010, OR 00011, XOR 00100, SLL 00101, SRL 00110, SUB 00111, SRA 01000, SLTU 01001.
  - M ops: {2'b10, funct3}.
- ALU op by instruction class:
  - Branches: BEQ/BNE=SUB, BLT/BGE=SLT, BLTU/BGEU=SLTU. Execute resolves polarity from funct3_o.
  - LUI, AUIPC, JAL, JALR, loads, stores: ADD.
- Immediates, sign-extended from the top instruction bit:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - JALR uses the I immediate.
- use_pc_o = 1 for AUIPC and JAL. lui_o = 1 for LUI.
- FENCE decodes as a legal NOP (all control flags 0).
- illegal_o = 1, with every write, memory, branch and jump flag forced to 0, for any of:
  - instr[1:0] != 11.
  - Unknown opcode, including SYSTEM.
  - OP funct7 not in {0000000, 0100000 only for funct3 000/101, 0000001 when ENABLE_M}.
  - Shift-immediate funct7 not in {0000000, 0100000 only for 101}.
  - Branch funct3 010 or 011.
  - Load funct3 011, 110 or 111.
  - Store funct3 > 010.
  - JALR funct3 != 000.
- An illegal bundle is still passed downstream with dec_valid_o = 1.
- FSM transitions:
  - RUN -> MEM_WAIT when a bundle with mem_read_o or mem_write_o is consumed (dec_valid_o && dec_ready_i).
  - MEM_WAIT -> RUN on mem_done_i.
  - MEM_WAIT -> RUN when the counter reaches MEM_TIMEOUT; mem_timeout_o pulses for 1 cycle.
- Counter: increments each MEM_WAIT cycle, saturates, and clears on entering RUN.
- mem_done_i is ignored in RUN. If mem_done_i arrives on the timeout cycle, mem_done_i wins and there is no pulse.
- mem_busy_o = (state==MEM_WAIT).
- flush_i has highest priority. Next cycle: dec_valid_o=0, FSM=RUN, counter=0, no accept in the flush cycle.
- Asynchronous reset mid-wait returns to the reset values immediately.

Test Plan:
- ADDI x1,x0,-1 (0xFFF00093), dec_ready_i=1 -> next cycle dec_valid_o=1, alu_op_o=00000, imm_o=0xFFFFFFFF, rd_o=1, use_imm_o=1, reg_write_o=1.
- LW x2,8(x1) (0x0080A103) consumed; mem_done_i after 5 cycles -> mem_busy_o high for 5 cycles, instr_ready_o=0 throughout, returns 1 the cycle after mem_done_i.
- MEM_TIMEOUT=4, SW with no mem_done_i -> mem_timeout_o pulses once after 4 wait cycles; FSM returns to RUN.
- MUL x3,x1,x2 (0x022081B3): with ENABLE_M=0 -> illegal_o=1, reg_write_o=0; with ENABLE_M=1 -> alu_op_o=10000, illegal_o=0.
- Back-to-back BEQ then JAL with dec_ready_i low for 3 cycles -> BEQ bundle held stable (B-imm sign-extended, alu_op_o=00111); JAL output the cycle after release, imm_o=J_imm, use_pc_o=1.
- flush_i during MEM_WAIT with a valid bundle held -> next cycle dec_valid_o=0, mem_busy_o=0, instr_ready_o=1.
